hwpe_ctrl_job_offloader: RTL and testbench
==========================================

// Module: hwpe_ctrl_job_offloader
// PURPOSE
//  Initiator side of the HWPE control-slave peripheral protocol: takes a job (register image) from a local
//  controller, acquires an HWPE context, programs the job registers, writes TRIGGER, then waits for completion.
//  Sits between a cluster-side sequencer (or test harness) and an HWPE control slave; one job in flight at a time.
// PARAMETERS
//  N_REGS        16     max job registers per job (1..48)
//  ID_WIDTH      8      width of periph_id_o / periph_r_id_i
//  REG_BASE_OFFS 'h40   byte offset of first job register; job reg k written at REG_BASE_OFFS+4*k
//  RETRY_CYCLES  16     idle cycles between a failed ACQUIRE read and the next attempt (>=1)
//  OFFLOADER_ID  0      constant driven on periph_id_o
// PORTS
//  clk_i            in   1            clock
//  rst_ni           in   1            async active-low reset
//  clear_i          in   1            sync abort to IDLE (see BEHAVIOUR)
//  job_valid_i      in   1            job offered
//  job_ready_o      out  1            job accepted when valid&ready
//  job_nb_regs_i    in   $clog2(N_REGS+1)  number of job registers to program
//  job_regs_i       in   N_REGS x 32  job register image, sampled on accept
//  job_id_o         out  8            job id returned by ACQUIRE, valid from ACQ_WAIT exit until next accept
//  job_done_o       out  1            1-cycle pulse: job completed
//  busy_o           out  1            high in every state except IDLE
//  evt_i            in   1            HWPE completion event (level or pulse, sampled in RUN)
//  periph_req_o     out  1            request
//  periph_gnt_i     in   1            grant
//  periph_add_o     out  32           byte address
//  periph_wen_o     out  1            1 = read, 0 = write
//  periph_be_o      out  4            always 4'hF
//  periph_data_o    out  32           write data
//  periph_id_o      out  ID_WIDTH     = OFFLOADER_ID
//  periph_r_data_i  in   32           read data
//  periph_r_valid_i in   1            read response valid
//  periph_r_id_i    in   ID_WIDTH     response id (ignored unless equal to OFFLOADER_ID)
// BEHAVIOUR
//  Reset: state IDLE; req=0, wen=1, add=0, data=0, job_id_o=0, job_done_o=0, busy_o=0, job_ready_o=1, counters 0.
//  Protocol: req asserted with add/wen/data stable until the gnt cycle; req may deassert only after gnt.
//   Reads complete on r_valid (>=1 cycle after gnt, matching id); writes complete on gnt, their r_valid ignored.
//  FSM:
//   IDLE:      job_ready_o=1; on accept latch regs, nb=min(job_nb_regs_i,N_REGS), k=0 -> ACQ_REQ.
//   ACQ_REQ:   read add=0x04 (ACQUIRE); on gnt -> ACQ_WAIT.
//   ACQ_WAIT:  on r_valid: data==32'hFFFF_FFFF -> RETRY (busy, no free context);
//              else job_id_o<=r_data[7:0] and -> PROG (nb>0) or TRIG (nb==0).
//   RETRY:     count RETRY_CYCLES cycles -> ACQ_REQ.
//   PROG:      write add=REG_BASE_OFFS+4*k, data=regs[k]; on gnt k++; after gnt with k==nb-1 -> TRIG.
//              Back-to-back writes allowed: next req presented the cycle after gnt.
//   TRIG:      write add=0x00, data=0; on gnt -> RUN.
//   RUN:       wait for completion (evt_i, or poll, see CONFIGURATION); then job_done_o=1 for 1 cycle -> IDLE.
//  Latency (zero-wait slave, r_valid 1 cycle after gnt, nb regs): accept -> TRIG gnt = 3+nb cycles.
//  evt_i high in the TRIG gnt cycle is ignored (belongs to an earlier job); only RUN samples it.
//  clear_i: if req high and not yet granted, abort is deferred to the gnt cycle; otherwise next state IDLE
//   immediately, no job_done_o; an outstanding read response is dropped. job_id_o retained.
//  rst_ni low at any time: all state to reset values asynchronously.
//  New job accepted in the cycle after job_done_o at the earliest (IDLE only).
// CONFIGURATION
//  HWPE_CTRL_OFFLOADER_POLL_EN defined: RUN ignores evt_i and loops POLL_REQ/POLL_WAIT reading add=0x0C
//   (STATUS); done when r_data==0, else wait RETRY_CYCLES and re-read.
//  Not defined: RUN waits for evt_i==1; no peripheral traffic in RUN.
// TESTING
//  1 job nb=3 regs {A,B,C}, zero-wait slave, ACQUIRE->0 -> writes 0x40=A,0x44=B,0x48=C, then 0x00=0; job_id_o=0.
//  2 ACQUIRE returns FFFF_FFFF twice then 1 -> exactly 3 ACQUIRE reads spaced >=RETRY_CYCLES; job_id_o=1.
//  3 nb=0 -> ACQUIRE then TRIGGER only; nb=20 with N_REGS=16 -> exactly 16 register writes.
//  4 gnt stalled 5 cycles on each write -> add/data stable throughout req; no write lost or duplicated.
//  5 evt_i pulse 3 cycles after TRIGGER gnt -> job_done_o single pulse next cycle; with POLL_EN STATUS reads
//    return 1,1,0 -> done after third read.
//  6 clear_i during PROG with ungranted req -> req held until gnt, then IDLE; rst_ni low in RUN -> all outputs reset.

Source files
------------

// File: rtl/hwpe_ctrl_job_offloader.sv
// hwpe_ctrl_job_offloader: initiator side of the HWPE control-slave protocol.
// Accepts one job (register image), acquires an HWPE context, programs the
// job registers, writes TRIGGER and waits for completion.
// Optional build macro HWPE_CTRL_OFFLOADER_POLL_EN: completion is detected by
// polling STATUS (0x0C) instead of waiting for evt_i.
//
// Handshakes: the job port transfers when job_valid_i & job_ready_o are high
// at a rising edge. On the peripheral port, periph_req_o with add/wen/data
// stays stable until the cycle periph_gnt_i is high; a read completes on a
// later periph_r_valid_i whose id matches OFFLOADER_ID, a write on its grant.
module hwpe_ctrl_job_offloader #(
  parameter int unsigned          N_REGS        = 16,
  parameter int unsigned          ID_WIDTH      = 8,
  parameter logic [31:0]          REG_BASE_OFFS = 32'h40,
  parameter int unsigned          RETRY_CYCLES  = 16,
  parameter logic [ID_WIDTH-1:0]  OFFLOADER_ID  = '0,
  localparam int unsigned         NB_W          = $clog2(N_REGS + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [NB_W-1:0]        job_nb_regs_i,
  input  logic [N_REGS*32-1:0]   job_regs_i,
  output logic [7:0]             job_id_o,
  output logic                   job_done_o,
  output logic                   busy_o,
  input  logic                   evt_i,
  output logic                   periph_req_o,
  input  logic                   periph_gnt_i,
  output logic [31:0]            periph_add_o,
  output logic                   periph_wen_o,
  output logic [3:0]             periph_be_o,
  output logic [31:0]            periph_data_o,
  output logic [ID_WIDTH-1:0]    periph_id_o,
  input  logic [31:0]            periph_r_data_i,
  input  logic                   periph_r_valid_i,
  input  logic [ID_WIDTH-1:0]    periph_r_id_i,
  output logic [3:0]             dbg_state_o
);

  localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned CNT_W = $clog2(RETRY_CYCLES + 1);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ACQ_REQ    = 4'd1,
    ST_ACQ_WAIT   = 4'd2,
    ST_RETRY      = 4'd3,
    ST_PROG       = 4'd4,
    ST_TRIG       = 4'd5,
    ST_RUN        = 4'd6,
    ST_POLL_REQ   = 4'd7,
    ST_POLL_WAIT  = 4'd8,
    ST_POLL_RETRY = 4'd9
  } state_t;

  state_t                    state_q, state_d;
  logic [N_REGS-1:0][31:0]   regs_q;
  logic [NB_W-1:0]           nb_q, nb_d;
  logic [IDX_W-1:0]          k_q, k_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [7:0]                job_id_q, job_id_d;
  logic                      done_q, done_d;
  logic                      clr_pend_q, clr_pend_d;
  logic                      accept;
  logic                      rsp_ok;

  assign job_ready_o   = (state_q == ST_IDLE) && !done_q;
  assign accept        = job_valid_i && job_ready_o;
  assign rsp_ok        = periph_r_valid_i && (periph_r_id_i == OFFLOADER_ID);
  assign busy_o        = (state_q != ST_IDLE);
  assign job_done_o    = done_q;
  assign job_id_o      = job_id_q;
  assign periph_be_o   = 4'hF;
  assign periph_id_o   = OFFLOADER_ID;
  assign dbg_state_o   = state_q;

`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
  logic unused_evt;
  assign unused_evt = evt_i;
`endif

  // State register and datapath registers; the job image is latched on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      regs_q     <= '0;
      nb_q       <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      job_id_q   <= '0;
      done_q     <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nb_q       <= nb_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      job_id_q   <= job_id_d;
      done_q     <= done_d;
      clr_pend_q <= clr_pend_d;
      if (accept) regs_q <= job_regs_i;
    end
  end

  // Next-state logic and peripheral request outputs.
  always_comb begin
    state_d       = state_q;
    nb_d          = nb_q;
    k_d           = k_q;
    cnt_d         = cnt_q;
    job_id_d      = job_id_q;
    done_d        = 1'b0;
    clr_pend_d    = clr_pend_q;
    periph_req_o  = 1'b0;
    periph_wen_o  = 1'b1;
    periph_add_o  = 32'h0;
    periph_data_o = 32'h0;

    case (state_q)
      ST_IDLE: begin
        clr_pend_d = 1'b0;
        if (accept) begin
          nb_d    = (job_nb_regs_i > NB_W'(N_REGS)) ? NB_W'(N_REGS) : job_nb_regs_i;
          k_d     = '0;
          cnt_d   = '0;
          state_d = ST_ACQ_REQ;
        end
      end
      ST_ACQ_REQ: begin
        periph_req_o = 1'b1;
        periph_add_o = 32'h04;
        if (periph_gnt_i) state_d = ST_ACQ_WAIT;
      end
      ST_ACQ_WAIT: begin
        if (rsp_ok) begin
          if (periph_r_data_i == 32'hFFFF_FFFF) begin
            cnt_d   = '0;
            state_d = ST_RETRY;
          end else begin
            job_id_d = periph_r_data_i[7:0];
            state_d  = (nb_q == '0) ? ST_TRIG : ST_PROG;
          end
        end
      end
      ST_RETRY: begin
        if (cnt_q == CNT_W'(RETRY_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_ACQ_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PROG: begin
        periph_req_o  = 1'b1;
        periph_wen_o  = 1'b0;
        periph_add_o  = REG_BASE_OFFS + (32'(k_q) << 2);
        periph_data_o = regs_q[k_q];
        if (periph_gnt_i) begin
          if (NB_W'(k_q) == nb_q - NB_W'(1)) begin
            k_d     = '0;
            state_d = ST_TRIG;
          end else begin
            k_d = k_q + IDX_W'(1);
          end
        end
      end
      ST_TRIG: begin
        periph_req_o = 1'b1;
        periph_wen_o = 1'b0;
        if (periph_gnt_i) state_d = ST_RUN;
      end
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
      ST_RUN: state_d = ST_POLL_REQ;
      ST_POLL_REQ: begin
        periph_req_o = 1'b1;
        periph_add_o = 32'h0C;
        if (periph_gnt_i) state_d = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        if (rsp_ok) begin
          if (periph_r_data_i == 32'h0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_POLL_RETRY;
          end
        end
      end
      ST_POLL_RETRY: begin
        if (cnt_q == CNT_W'(RETRY_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_POLL_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`else
      // evt_i is only looked at here, so an event left over from a previous
      // job during the TRIGGER grant cannot complete this one.
      ST_RUN: begin
        if (evt_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Abort: an ungranted request must stay up, so the abort waits for its grant.
    if ((clear_i || clr_pend_q) && (state_q != ST_IDLE)) begin
      if (periph_req_o && !periph_gnt_i) begin
        clr_pend_d = 1'b1;
      end else begin
        state_d    = ST_IDLE;
        done_d     = 1'b0;
        clr_pend_d = 1'b0;
        job_id_d   = job_id_q;
        k_d        = '0;
      end
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_job_offloader.sv
// Self-checking bench for hwpe_ctrl_job_offloader: a zero-wait/stallable
// slave model, a transaction scoreboard fed by the job tasks, and a monitor
// that pops and compares on every granted request.
module tb_hwpe_ctrl_job_offloader;

  localparam int N_REGS = 16;
  localparam int RETRY  = 16;
  localparam int NB_W   = $clog2(N_REGS + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // DUT signals
  logic                 clear_i = 1'b0;
  logic                 job_valid = 1'b0;
  logic                 job_ready;
  logic [NB_W-1:0]      job_nb = '0;
  logic [N_REGS*32-1:0] job_regs = '0;
  logic [7:0]           job_id;
  logic                 job_done;
  logic                 busy;
  logic                 evt = 1'b0;
  logic                 req;
  logic                 gnt = 1'b0;
  logic [31:0]          add;
  logic                 wen;
  logic [3:0]           be;
  logic [31:0]          wdata;
  logic [7:0]           pid;
  logic [31:0]          r_data = '0;
  logic                 r_valid = 1'b0;
  logic [7:0]           r_id = '0;
  logic [3:0]           dbg_state;

  hwpe_ctrl_job_offloader dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i),
    .job_valid_i(job_valid), .job_ready_o(job_ready),
    .job_nb_regs_i(job_nb), .job_regs_i(job_regs),
    .job_id_o(job_id), .job_done_o(job_done), .busy_o(busy), .evt_i(evt),
    .periph_req_o(req), .periph_gnt_i(gnt), .periph_add_o(add),
    .periph_wen_o(wen), .periph_be_o(be), .periph_data_o(wdata),
    .periph_id_o(pid), .periph_r_data_i(r_data), .periph_r_valid_i(r_valid),
    .periph_r_id_i(r_id), .dbg_state_o(dbg_state)
  );

  // scoreboard state: {wen, add, data}
  logic [64:0] exp_q[$];
  logic [31:0] acq_q[$];
  logic [31:0] status_q[$];
  int          acq_cyc[$];
  int total = 0;
  int bad = 0;
  int stall_w = 0;
  int done_cnt = 0;
  bit trig_seen = 0;
  int trig_cyc = 0;
  int acc_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // slave model: grants (optionally stalling writes), answers reads one cycle later
  initial begin : slave
    bit pend;
    logic [31:0] pend_data;
    int wcnt;
    pend = 0; pend_data = '0; wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      r_valid = 1'b0;
      gnt     = 1'b0;
      if (!rst_n) begin
        pend = 0;
        wcnt = 0;
      end else begin
        if (pend) begin
          r_valid = 1'b1;
          r_data  = pend_data;
          r_id    = 8'h00;
          pend    = 0;
        end
        if (req) begin
          if (!wen && wcnt < stall_w) begin
            wcnt++;
          end else begin
            gnt  = 1'b1;
            wcnt = 0;
            if (wen) begin
              pend = 1;
              if (add == 32'h4) pend_data = (acq_q.size() > 0) ? acq_q.pop_front() : 32'h0;
              else              pend_data = (status_q.size() > 0) ? status_q.pop_front() : 32'h0;
            end
          end
        end
      end
    end
  end

  // monitor: compares every granted request, checks stability while stalled
  initial begin : monitor
    logic [64:0] e;
    bit hold_valid;
    logic [31:0] hold_add, hold_data;
    bit prev_done;
    hold_valid = 0; hold_add = '0; hold_data = '0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (rst_n && req) begin
        if (gnt) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_txn: got wen=%0b add=%0h data=%0h, expected none", wen, add, wdata);
          end else begin
            e = exp_q.pop_front();
            check("txn_wen", 64'(wen), 64'(e[64]));
            check("txn_add", 64'(add), 64'(e[63:32]));
            if (!e[64]) check("txn_data", 64'(wdata), 64'(e[31:0]));
          end
          if (wen && add == 32'h4) acq_cyc.push_back(cyc);
          if (!wen && add == 32'h0) begin
            trig_seen = 1;
            trig_cyc  = cyc;
          end
          hold_valid = 0;
        end else begin
          if (hold_valid) begin
            check("stall_add_stable", 64'(add), 64'(hold_add));
            check("stall_data_stable", 64'(wdata), 64'(hold_data));
          end
          hold_valid = 1;
          hold_add   = add;
          hold_data  = wdata;
        end
      end else begin
        hold_valid = 0;
      end
      if (rst_n && job_done) begin
        done_cnt++;
        check("done_single_cycle", 64'(prev_done), 64'd0);
      end
      prev_done = rst_n && job_done;
    end
  end

  function automatic logic [31:0] reg_word(input int j, input int k);
    return {8'(j), 8'(k), 16'hBEEF};
  endfunction

  // offer a job and wait for it to be accepted (bounded)
  task automatic offer_job(input int nb);
    int t;
    t = 0;
    job_nb    = NB_W'(nb);
    job_valid = 1'b1;
    while (!job_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!job_ready) check("accept_timeout", 64'd0, 64'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  // push expectations for a job and run it to completion
  task automatic run_job(input int nb, input int n_eff, input logic [7:0] exp_id,
                         input bit stale_evt, input bit chk_lat, input bit to_done);
    int n_acq, t, d0;
    n_acq = acq_q.size();
    for (int i = 0; i < n_acq; i++) exp_q.push_back({1'b1, 32'h4, 32'h0});
    for (int k = 0; k < n_eff; k++)
      exp_q.push_back({1'b0, 32'h40 + 32'(4 * k), job_regs[k*32 +: 32]});
    exp_q.push_back({1'b0, 32'h0, 32'h0});
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
    if (to_done) begin
      for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 32'hC, 32'h0});
      status_q.push_back(32'h1); status_q.push_back(32'h1); status_q.push_back(32'h0);
    end
`endif
    d0 = done_cnt;
    trig_seen = 0;
    offer_job(nb);
    if (stale_evt) evt = 1'b1;
    t = 0;
    while (!trig_seen && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    evt = 1'b0;
    if (!trig_seen) begin
      check("trigger_timeout", 64'd0, 64'd1);
      return;
    end
    if (chk_lat) check("accept_to_trigger", 64'(trig_cyc - acc_cyc), 64'(3 + n_eff));
    if (!to_done) return;
`ifdef HWPE_CTRL_OFFLOADER_POLL_EN
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk); t++;
    end
    check("poll_done", 64'(done_cnt - d0), 64'd1);
`else
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("no_early_done", 64'(done_cnt), 64'(d0));
    evt = 1'b1;
    @(posedge clk); #1;
    evt = 1'b0;
    @(negedge clk);
    check("done_after_evt", 64'(job_done), 64'd1);
    check("ready_low_in_done", 64'(job_ready), 64'd0);
    check("busy_low_in_done", 64'(busy), 64'd0);
`endif
    check("job_id", 64'(job_id), 64'(exp_id));
    @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("ready_after_done", 64'(job_ready), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 64'(req), 64'd0);
    check({tag, "_wen"}, 64'(wen), 64'd1);
    check({tag, "_add"}, 64'(add), 64'd0);
    check({tag, "_data"}, 64'(wdata), 64'd0);
    check({tag, "_job_id"}, 64'(job_id), 64'd0);
    check({tag, "_done"}, 64'(job_done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(job_ready), 64'd1);
  endtask

  initial begin : stimulus
    int t, d0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("be_const", 64'(be), 64'hF);
    check("id_const", 64'(pid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // job 1: nb=3, A/B/C, ACQUIRE->0, stale evt through TRIGGER grant
    job_regs = '0;
    job_regs[0*32 +: 32] = 32'hAAAA_0001;
    job_regs[1*32 +: 32] = 32'hBBBB_0002;
    job_regs[2*32 +: 32] = 32'hCCCC_0003;
    acq_q.push_back(32'h0);
    run_job(3, 3, 8'h00, 1'b1, 1'b1, 1'b1);

    // job 2: two busy ACQUIREs then id 1
    for (int k = 0; k < N_REGS; k++) job_regs[k*32 +: 32] = reg_word(2, k);
    acq_cyc.delete();
    acq_q.push_back(32'hFFFF_FFFF); acq_q.push_back(32'hFFFF_FFFF); acq_q.push_back(32'h1);
    run_job(2, 2, 8'h01, 1'b0, 1'b0, 1'b1);
    check("acq_count", 64'(acq_cyc.size()), 64'd3);
    if (acq_cyc.size() == 3) begin
      check("acq_spacing_1", 64'(acq_cyc[1] - acq_cyc[0]), 64'(RETRY + 2));
      check("acq_spacing_2", 64'(acq_cyc[2] - acq_cyc[1]), 64'(RETRY + 2));
    end

    // job 3: nb=0 -> ACQUIRE then TRIGGER only
    acq_q.push_back(32'h7);
    run_job(0, 0, 8'h07, 1'b0, 1'b1, 1'b1);

    // job 4: nb=20 clamps to 16 writes
    for (int k = 0; k < N_REGS; k++) job_regs[k*32 +: 32] = reg_word(4, k);
    acq_q.push_back(32'h8);
    run_job(20, 16, 8'h08, 1'b0, 1'b1, 1'b1);

    // job 5: every write stalled 5 cycles
    for (int k = 0; k < N_REGS; k++) job_regs[k*32 +: 32] = reg_word(5, k);
    stall_w = 5;
    acq_q.push_back(32'h9);
    run_job(4, 4, 8'h09, 1'b0, 1'b0, 1'b1);

    // clear during a stalled PROG write: request held until grant, then IDLE
    for (int k = 0; k < N_REGS; k++) job_regs[k*32 +: 32] = reg_word(6, k);
    acq_q.push_back(32'h22);
    exp_q.push_back({1'b1, 32'h4, 32'h0});
    exp_q.push_back({1'b0, 32'h40, job_regs[31:0]});
    d0 = done_cnt;
    offer_job(4);
    t = 0;
    do begin
      @(negedge clk); t++;
    end while (!(req && !wen && !gnt) && t < 200);
    @(posedge clk); #1;
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk); t++;
    end
    @(negedge clk);
    check("clear_idle", 64'(busy), 64'd0);
    check("clear_req_low", 64'(req), 64'd0);
    check("clear_no_done", 64'(done_cnt), 64'(d0));
    check("clear_job_id_kept", 64'(job_id), 64'h22);
    check("clear_exp_q_drained", 64'(exp_q.size()), 64'd0);
    stall_w = 0;
    repeat (3) @(posedge clk);
    #1;

    // reset while in RUN
    for (int k = 0; k < N_REGS; k++) job_regs[k*32 +: 32] = reg_word(7, k);
    acq_q.push_back(32'h5);
    run_job(2, 2, 8'h05, 1'b0, 1'b0, 1'b0);
    check("run_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("run_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // recovery job after reset
    for (int k = 0; k < N_REGS; k++) job_regs[k*32 +: 32] = reg_word(8, k);
    acq_q.push_back(32'h33);
    run_job(1, 1, 8'h33, 1'b0, 1'b1, 1'b1);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
